// File: rtl/restoring_divider.sv
// restoring_divider
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit
// quotient and N-bit remainder, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a start accepted with divisor 0 skips the
// iterations and completes directly (done in the cycle after acceptance,
// busy never asserts). Without the macro, divisor 0 runs the full 2N
// iterations and produces the same result values.
module restoring_divider #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero
);

  localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [2*N-1:0]   dvd_r;        // dividend shifting out, quotient shifting in
  logic [N-1:0]     dvs_r;
  logic [N:0]       prem_r;       // partial remainder
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [2*N-1:0]   quotient_r;
  logic [N-1:0]     remainder_r;
  logic             div_zero_r;

  logic [N:0]       shifted_s;
  logic [N+1:0]     trial_s;
  logic [N:0]       prem_next_s;
  logic             qbit_s;
  logic [2*N-1:0]   dvd_next_s;

  // One restoring iteration: shift in the next dividend bit, trial-subtract.
  always_comb begin
    shifted_s   = {prem_r[N-1:0], dvd_r[2*N-1]};
    trial_s     = {1'b0, shifted_s} - {2'b00, dvs_r};
    prem_next_s = shifted_s;
    qbit_s      = 1'b0;
    if (trial_s[N+1] == 1'b0) begin
      prem_next_s = trial_s[N:0];
      qbit_s      = 1'b1;
    end else begin
      prem_next_s = shifted_s;
      qbit_s      = 1'b0;
    end
    dvd_next_s = {dvd_r[2*N-2:0], qbit_s};
  end

  // Control FSM, datapath registers and registered outputs.
  // A start is taken in IDLE and also on the edge that ends the DONE cycle,
  // giving one division every 2N+1 cycles; starts during RUN are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      dvd_r       <= {(2*N){1'b0}};
      dvs_r       <= {N{1'b0}};
      prem_r      <= {(N+1){1'b0}};
      cnt_r       <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {(2*N){1'b0}};
      remainder_r <= {N{1'b0}};
      div_zero_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            prem_r <= {(N+1){1'b0}};
            cnt_r  <= {CW{1'b0}};
`ifdef DIV_ZERO_FAST_EN
            if (divisor == {N{1'b0}}) begin
              quotient_r  <= {(2*N){1'b1}};
              remainder_r <= dividend[N-1:0];
              div_zero_r  <= 1'b1;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= ST_DONE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= ST_RUN;
            end
`else
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
`endif
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          prem_r <= prem_next_s;
          dvd_r  <= dvd_next_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            quotient_r  <= dvd_next_s;
            remainder_r <= prem_next_s[N-1:0];
            div_zero_r  <= (dvs_r == {N{1'b0}});
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (N = 16).
module tb_restoring_divider;

  localparam int N = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_zero;

  int checks = 0;
  int errors = 0;

  restoring_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one division and wait for done. lat counts edges after the
  // accepting edge up to the edge that raised done.
  task automatic run_div(input logic [2*N-1:0] a, input logic [N-1:0] b,
                         output int lat, output logic busy_e0,
                         output int overlap, output logic done_after);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    busy_e0 = busy;
    lat     = 0;
    overlap = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
    end
    @(posedge clk);
    #1;
    done_after = done;
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %0b want 0", div_zero); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_no_done got %0d pulses want 0", pulses); end
  endtask

  task automatic test_basic();
    int lat, ov; logic b0, da;
    run_div(32'd100, 16'd7, lat, b0, ov, da);
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_q got %0d want 14", quotient); end
    checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL basic_r got %0d want 2", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL basic_dz got %0b want 0", div_zero); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency got %0d want 32", lat); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy_after_accept got %0b want 1", b0); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL basic_busy_done_overlap got %0d want 0", ov); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got %0b want 0", da); end
  endtask

  task automatic test_inverse();
    int lat, ov; logic b0, da;
    run_div(32'hFFFF_FFFF, 16'hFFFF, lat, b0, ov, da);
    checks++; if (quotient !== 32'h0001_0001) begin errors++; $display("FAIL inv1_q got %h want 00010001", quotient); end
    checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL inv1_r got %h want 0", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL inv1_dz got %0b want 0", div_zero); end
    run_div(32'd1000000, 16'd1000, lat, b0, ov, da);
    checks++; if (quotient !== 32'd1000) begin errors++; $display("FAIL inv2_q got %0d want 1000", quotient); end
    checks++; if (remainder !== 16'd0) begin errors++; $display("FAIL inv2_r got %0d want 0", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL inv2_dz got %0b want 0", div_zero); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL inv2_latency got %0d want 32", lat); end
  endtask

  task automatic test_div_zero();
    int lat, ov; logic b0, da;
    int exp_lat;
    logic exp_b0;
`ifdef DIV_ZERO_FAST_EN
    exp_lat = 0;   // done already high in the cycle right after acceptance
    exp_b0  = 1'b0;
`else
    exp_lat = 32;
    exp_b0  = 1'b1;
`endif
    run_div(32'h1234_5678, 16'h0, lat, b0, ov, da);
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q got %h want ffffffff", quotient); end
    checks++; if (remainder !== 16'h5678) begin errors++; $display("FAIL dz_r got %h want 5678", remainder); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b want 1", div_zero); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL dz_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (b0 !== exp_b0) begin errors++; $display("FAIL dz_busy got %0b want %0b", b0, exp_b0); end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    @(negedge clk);
    dividend = 32'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    dividend = 32'd999; divisor = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL busy_start_q got %0d want 14", quotient); end
    checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL busy_start_r got %0d want 2", remainder); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    int lat, ov; logic b0, da;
    @(negedge clk);
    dividend = 32'hFFFF_FFFF; divisor = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL abort_q got %h want 0", quotient); end
    checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL abort_r got %h want 0", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL abort_dz got %0b want 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", pulses); end
    run_div(32'd7, 16'd7, lat, b0, ov, da);
    checks++; if (quotient !== 32'd1) begin errors++; $display("FAIL after_abort_q got %0d want 1", quotient); end
    checks++; if (remainder !== 16'd0) begin errors++; $display("FAIL after_abort_r got %0d want 0", remainder); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL after_abort_latency got %0d want 32", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverse();
    test_div_zero();
    test_start_while_busy();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
